conv_window_engine: RTL and testbench

Parametrised, handshaked convolution engine: multiply-accumulates one MAX_SIZE x MAX_SIZE pixel window against a signed kernel, then normalises and saturates the sum to a pixel.
- Run-time kernel size (1..MAX_SIZE) and normalisation shift; LANES MACs per cycle.
- Valid/ready on both sides.
- Sits between the window line-buffer and the FAST/blur output stage; replaces the fixed 3x3 single-MAC blur core.

---
 rtl/conv_window_engine_pkg.sv | 36 +++
 rtl/conv_window_engine_if.sv | 31 +++
 rtl/conv_window_engine_mac_lane.sv | 24 ++
 rtl/conv_window_engine.sv | 179 +++++++++++++++++
 tb/tb_conv_window_engine.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_engine_pkg.sv
// conv_pkg: shared types and helpers for the convolution window engine.
// Holds the FSM state enum, accumulator sizing and pixel saturation.
package conv_pkg;

    localparam int KSIZE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        NORM,
        OUT
    } conv_state_t;

    // Signed accumulator width that cannot overflow for a full window.
    function automatic int acc_width(input int pix_w,
                                     input int coef_w,
                                     input int max_size);
        return pix_w + coef_w + $clog2(max_size * max_size) + 1;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^pix_w-1].
    function automatic logic [31:0] saturate_pixel(
        input logic signed [63:0] v,
        input int                 pix_w
    );
        logic signed [63:0] hi;
        hi = (64'sd1 <<< pix_w) - 64'sd1;
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi[31:0];
        else
            return v[31:0];
    endfunction

endpackage

// File: rtl/conv_window_engine_if.sv
// conv_window_engine_if: job (window/kernel/config) and result handshakes.
// master = job source / result sink, slave = engine.
interface conv_window_engine_if #(
    parameter int MAX_SIZE = 7,
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8
);
    import conv_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    logic [MAX_SIZE*MAX_SIZE*PIX_W-1:0] window;
    logic [MAX_SIZE*MAX_SIZE*COEF_W-1:0] kernel;
    logic [KSIZE_W-1:0]                 ksize;
    logic [4:0]                         norm_shift;
    logic                               out_valid;
    logic                               out_ready;
    logic [PIX_W-1:0]                   out_pixel;
    logic                               out_err;

    modport master (
        output in_valid, window, kernel, ksize, norm_shift, out_ready,
        input  in_ready, out_valid, out_pixel, out_err
    );

    modport slave (
        input  in_valid, window, kernel, ksize, norm_shift, out_ready,
        output in_ready, out_valid, out_pixel, out_err
    );

endinterface

// File: rtl/conv_window_engine_mac_lane.sv
// conv_mac_lane: unsigned pixel x signed coefficient product, gated to 0.
// Ports: pix_i, coef_i, en_i (column in range) -> prod_o (signed).
module conv_mac_lane #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
) (
    input  logic [PIX_W-1:0]                pix_i,
    input  logic signed [COEF_W-1:0]        coef_i,
    input  logic                            en_i,
    output logic signed [PIX_W+COEF_W:0]    prod_o
);

    localparam int PW = PIX_W + COEF_W + 1;

    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;

    always_comb begin
        a      = PW'($signed({1'b0, pix_i}));
        b      = PW'(coef_i);
        prod_o = en_i ? a * b : '0;
    end

endmodule

// File: rtl/conv_window_engine.sv
// conv_window_engine: MACs a ksize x ksize window against a signed kernel,
// LANES columns per cycle, then shifts and saturates to one pixel.
// Ports: clk, n_rst (async, active-low), clear (sync abort),
//        bus (conv_window_engine_if.slave: job in, result out).
// Build option: define CONV_ROUND_EN for round-half-up before the shift.
module conv_window_engine
    import conv_pkg::*;
#(
    parameter int MAX_SIZE = 7,
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8,
    parameter int LANES    = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    conv_window_engine_if.slave bus
);

    localparam int ACC_W  = acc_width(PIX_W, COEF_W, MAX_SIZE);
    localparam int NW     = ACC_W + 1;
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int WIN_W  = MAX_SIZE * MAX_SIZE * PIX_W;
    localparam int KER_W  = MAX_SIZE * MAX_SIZE * COEF_W;

    conv_state_t               state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [PIX_W-1:0]          out_pixel_q;
    logic                      out_err_q;
    logic                      err_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [KSIZE_W-1:0]        x_q;
    logic [KSIZE_W-1:0]        y_q;
    logic [WIN_W-1:0]          win_q;
    logic [KER_W-1:0]          ker_q;
    logic [KSIZE_W-1:0]        ksize_q;
    logic [4:0]                shift_q;

    logic signed [PROD_W-1:0]  prod [LANES];
    logic signed [ACC_W-1:0]   lane_sum;
    logic                      bad_ks;
    logic                      row_end;
    logic                      last_row;
    logic signed [NW-1:0]      pre;
    logic signed [NW-1:0]      shifted;
    logic [PIX_W-1:0]          sat;

    // ksize_q is stored as 0 on error jobs, so every lane stays gated and
    // the window index never leaves the array.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        int   col;
        int   idx;
        logic en;

        always_comb begin
            col = int'(x_q) + i;
            en  = col < int'(ksize_q);
            idx = en ? int'(y_q) * MAX_SIZE + col : 0;
        end

        conv_mac_lane #(
            .PIX_W  (PIX_W),
            .COEF_W (COEF_W)
        ) u_lane (
            .pix_i  (win_q[idx*PIX_W +: PIX_W]),
            .coef_i (ker_q[idx*COEF_W +: COEF_W]),
            .en_i   (en),
            .prod_o (prod[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum += ACC_W'(prod[i]);
    end

    always_comb begin
        bad_ks   = (bus.ksize == '0) || (int'(bus.ksize) > MAX_SIZE);
        row_end  = int'(x_q) + LANES >= int'(ksize_q);
        last_row = row_end && (y_q == ksize_q - KSIZE_W'(1));
    end

    always_comb begin
        pre = NW'(acc_q);
`ifdef CONV_ROUND_EN
        if (shift_q != '0)
            pre = pre + (NW'(1) <<< (shift_q - 5'd1));
`endif
        shifted = pre >>> shift_q;
        sat     = PIX_W'(saturate_pixel(64'(shifted), PIX_W));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_err_q   <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            win_q       <= '0;
            ker_q       <= '0;
            ksize_q     <= '0;
            shift_q     <= '0;
        end else if (clear) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        win_q      <= bus.window;
                        ker_q      <= bus.kernel;
                        shift_q    <= bus.norm_shift;
                        acc_q      <= '0;
                        x_q        <= '0;
                        y_q        <= '0;
                        in_ready_q <= 1'b0;
                        if (bad_ks) begin
                            err_q   <= 1'b1;
                            ksize_q <= '0;
                            state_q <= NORM;
                        end else begin
                            err_q   <= 1'b0;
                            ksize_q <= bus.ksize;
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + lane_sum;
                    if (row_end) begin
                        x_q <= '0;
                        if (last_row) begin
                            y_q     <= '0;
                            state_q <= NORM;
                        end else begin
                            y_q <= y_q + KSIZE_W'(1);
                        end
                    end else begin
                        x_q <= x_q + KSIZE_W'(LANES);
                    end
                end
                NORM: begin
                    out_valid_q <= 1'b1;
                    out_err_q   <= err_q;
                    out_pixel_q <= err_q ? '0 : sat;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_conv_window_engine.sv
// tb_conv_window_engine: directed and random jobs on LANES=1 and LANES=4
// engines, checked against a plain-arithmetic convolution model.
module tb_conv_window_engine;

    localparam int MS = 7;
    localparam int PW = 8;
    localparam int CW = 8;

    logic clk       = 1'b0;
    logic n_rst     = 1'b0;
    logic clear     = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b1;
    int   sel       = 0;

    logic [MS*MS*PW-1:0] win_v = '0;
    logic [MS*MS*CW-1:0] ker_v = '0;
    logic [3:0]          ks_v  = '0;
    logic [4:0]          sh_v  = '0;

    int pix [MS][MS];
    int cof [MS][MS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_engine_if #(.MAX_SIZE(MS), .PIX_W(PW), .COEF_W(CW)) b1 ();
    conv_window_engine_if #(.MAX_SIZE(MS), .PIX_W(PW), .COEF_W(CW)) b4 ();

    assign b1.in_valid   = in_valid && (sel == 0);
    assign b4.in_valid   = in_valid && (sel == 1);
    assign b1.out_ready  = (sel == 0) ? out_ready : 1'b1;
    assign b4.out_ready  = (sel == 1) ? out_ready : 1'b1;
    assign b1.window     = win_v;
    assign b4.window     = win_v;
    assign b1.kernel     = ker_v;
    assign b4.kernel     = ker_v;
    assign b1.ksize      = ks_v;
    assign b4.ksize      = ks_v;
    assign b1.norm_shift = sh_v;
    assign b4.norm_shift = sh_v;

    conv_window_engine #(
        .MAX_SIZE(MS), .PIX_W(PW), .COEF_W(CW), .LANES(1)
    ) u1 (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (b1.slave)
    );

    conv_window_engine #(
        .MAX_SIZE(MS), .PIX_W(PW), .COEF_W(CW), .LANES(4)
    ) u4 (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (b4.slave)
    );

    logic          c_in_ready;
    logic          c_out_valid;
    logic [PW-1:0] c_out_pixel;
    logic          c_out_err;

    assign c_in_ready  = (sel == 1) ? b4.in_ready  : b1.in_ready;
    assign c_out_valid = (sel == 1) ? b4.out_valid : b1.out_valid;
    assign c_out_pixel = (sel == 1) ? b4.out_pixel : b1.out_pixel;
    assign c_out_err   = (sel == 1) ? b4.out_err   : b1.out_err;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: sum over the active square, optional rounding, shift, clamp.
    function automatic int model(input int ks, input int sh);
        int s;
        int v;
        s = 0;
        if (ks < 1 || ks > MS)
            return 0;
        for (int y = 0; y < ks; y++)
            for (int x = 0; x < ks; x++)
                s += pix[y][x] * cof[y][x];
`ifdef CONV_ROUND_EN
        if (sh > 0)
            s += 1 << (sh - 1);
`endif
        v = s >>> sh;
        if (v < 0)
            return 0;
        if (v > 255)
            return 255;
        return v;
    endfunction

    task automatic fill(input int p, input int c);
        for (int y = 0; y < MS; y++)
            for (int x = 0; x < MS; x++) begin
                pix[y][x] = p;
                cof[y][x] = c;
            end
    endtask

    task automatic rand_fill();
        for (int y = 0; y < MS; y++)
            for (int x = 0; x < MS; x++) begin
                pix[y][x] = int'($urandom_range(0, 255));
                cof[y][x] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic pack();
        for (int y = 0; y < MS; y++)
            for (int x = 0; x < MS; x++) begin
                win_v[(y*MS+x)*PW +: PW] = PW'(pix[y][x]);
                ker_v[(y*MS+x)*CW +: CW] = CW'(cof[y][x]);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int s, input int ks,
                           input int sh, input int stall,
                           output int got);
        int L, n, elat, ep, ee, cyc;
        sel       = s;
        pack();
        ks_v      = 4'(ks);
        sh_v      = 5'(sh);
        out_ready = (stall == 0);
        L    = (s == 1) ? 4 : 1;
        ee   = (ks < 1 || ks > MS) ? 1 : 0;
        n    = ee ? 0 : ks * ((ks + L - 1) / L);
        elat = ee ? 2 : n + 2;
        ep   = model(ks, sh);
        check("ready_idle", 32'(c_in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ready_busy", 32'(c_in_ready), 32'd0);
        // Inputs after the accept cycle must not matter.
        win_v = ~win_v;
        ker_v = ~ker_v;
        ks_v  = ~ks_v;
        sh_v  = ~sh_v;
        cyc = 1;
        while (c_out_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(elat));
        check("pixel", 32'(c_out_pixel), 32'(ep));
        check("err", 32'(c_out_err), 32'(ee));
        got = int'(c_out_pixel);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                tick();
                check("stall_valid", 32'(c_out_valid), 32'd1);
                check("stall_ready", 32'(c_in_ready), 32'd0);
                check("stall_pixel", 32'(c_out_pixel), 32'(ep));
                check("stall_err", 32'(c_out_err), 32'(ee));
            end
            out_ready = 1'b1;
        end
        tick();
        check("drop_valid", 32'(c_out_valid), 32'd0);
        check("ready_after", 32'(c_in_ready), 32'd1);
        check("pixel_kept", 32'(c_out_pixel), 32'(ep));
    endtask

    initial begin
        int got;
        int seen;
        int ks, sh, st;

        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", 32'(b1.in_ready), 32'd1);
        check("rst_valid1", 32'(b1.out_valid), 32'd0);
        check("rst_pixel1", 32'(b1.out_pixel), 32'd0);
        check("rst_err1", 32'(b1.out_err), 32'd0);
        check("rst_ready4", 32'(b4.in_ready), 32'd1);
        check("rst_valid4", 32'(b4.out_valid), 32'd0);
        n_rst = 1'b1;
        tick();

        // 3x3 of 9s with unit kernel: 81 after 11 cycles.
        fill(9, 1);
        run_job(0, 3, 0, 0, got);
        check("sum81", 32'(got), 32'd81);

        // LANES=4, ksize 7: N=14, saturates at 255.
        run_job(1, 7, 0, 0, got);
        check("l4_sat", 32'(got), 32'd255);

        // 900 >> 3.
        fill(100, 1);
        run_job(0, 3, 3, 0, got);
`ifdef CONV_ROUND_EN
        check("norm_round", 32'(got), 32'd113);
`else
        check("norm_trunc", 32'(got), 32'd112);
`endif

        // Negative sum clamps to 0.
        fill(50, 0);
        cof[1][1] = -1;
        run_job(0, 3, 0, 0, got);
        check("neg_clamp", 32'(got), 32'd0);

        fill(255, 127);
        run_job(1, 7, 0, 0, got);
        check("pos_clamp", 32'(got), 32'd255);

        // Backpressure.
        fill(20, 2);
        run_job(0, 2, 2, 5, got);
        run_job(1, 5, 4, 5, got);

        // Illegal sizes.
        run_job(0, 0, 0, 0, got);
        run_job(0, 8, 0, 0, got);
        run_job(1, 15, 0, 2, got);

        // 1x1 window; everything else poisoned.
        fill(255, 127);
        pix[0][0] = 7;
        cof[0][0] = 3;
        run_job(0, 1, 0, 0, got);
        check("k1", 32'(got), 32'd21);
        run_job(1, 1, 0, 0, got);
        check("k1_l4", 32'(got), 32'd21);

        // Abort mid-job at T+4.
        sel = 0;
        fill(9, 1);
        pack();
        ks_v = 4'd3;
        sh_v = 5'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_valid", 32'(c_out_valid), 32'd0);
        check("abort_ready", 32'(c_in_ready), 32'd1);
        tick();
        fill(3, 2);
        run_job(0, 3, 1, 0, got);
        check("after_abort", 32'(got), 32'd27);

        // clear wins over a job offered in IDLE.
        sel = 0;
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        in_valid = 1'b0;
        clear = 1'b0;
        check("clr_noaccept", 32'(c_in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (c_out_valid === 1'b1)
                seen = 1;
            tick();
        end
        check("clr_novalid", 32'(seen), 32'd0);

        // Async reset in the middle of a job.
        fill(9, 1);
        run_job(1, 7, 0, 0, got);
        sel = 1;
        pack();
        ks_v = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_rst = 1'b0;
        #2;
        check("arst_ready", 32'(c_in_ready), 32'd1);
        check("arst_valid", 32'(c_out_valid), 32'd0);
        check("arst_pixel", 32'(c_out_pixel), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        check("arst_idle", 32'(c_in_ready), 32'd1);

        // Random jobs on both engines.
        for (int i = 0; i < 30; i++) begin
            rand_fill();
            ks = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                sh = int'($urandom_range(13, 31));
            else
                sh = int'($urandom_range(0, 12));
            st = int'($urandom_range(0, 3));
            run_job(i % 2, ks, sh, st, got);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
